// File: rtl/dm_acc_pkg.sv
// Shared types for the data-memory access controller.
// Size codes, FSM states and the alignment rule.
package dm_acc_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_READ,
      ST_WRITE,
      ST_RESP,
      ST_ERR
   } st_t;

   function automatic logic is_aligned(
      input logic [1:0] size,
      input logic [1:0] a
   );
      logic ok;
      case (size)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~a[0];
         SZ_WORD: ok = (a == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Request/response handshake between MEM stage and controller.
// master = pipeline side, slave = controller side.
interface dm_access_ctrl_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_size,
      output req_signed, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size,
      input  req_signed, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dm_lane_unit.sv
// Little-endian lane handling for the data memory.
// Extracts/extends load lanes and merges store lanes.
module dm_lane_unit
   import dm_acc_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sgn,
   output logic [31:0] ext,
   output logic [31:0] merged
);

   logic [7:0]  b;
   logic [15:0] h;

   // Pick the addressed lane and extend it to 32 bits.
   always_comb begin
      b   = rd_word[{lane, 3'b000} +: 8];
      h   = lane[1] ? rd_word[31:16] : rd_word[15:0];
      ext = rd_word;
      case (size)
         SZ_BYTE: ext = {{24{sgn & b[7]}}, b};
         SZ_HALF: ext = {{16{sgn & h[15]}}, h};
         default: ext = rd_word;
      endcase
   end

   // Replace only the target lane of the old word.
   always_comb begin
      merged = old_word;
      case (size)
         SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
         SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/dm_access_ctrl.sv
// CPU-side initiator for the 1 KiB data memory.
// Byte/half/word loads and stores, RMW for sub-word stores.
module dm_access_ctrl
   import dm_acc_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   dm_access_ctrl_if.slave   bus,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_din,
   output logic              dm_we,
   input  logic [DATA_W-1:0] dm_dout
);

   st_t               state;
   st_t               nxt;
   logic              we_q;
   logic              sgn_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       merge_q;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic [31:0]       ext;
   logic [31:0]       merged;
   logic              accept;
   logic              ok;

   dm_lane_unit u_lane (
      .rd_word  (dm_dout),
      .old_word (merge_q),
      .wdata    (wdata_q),
      .lane     (addr_q[1:0]),
      .size     (size_q),
      .sgn      (sgn_q),
      .ext      (ext),
      .merged   (merged)
   );

   assign ok     = is_aligned(bus.req_size, bus.req_addr[1:0]);
   assign accept = bus.req_valid & bus.req_ready;

   assign dm_addr       = {addr_q[ADDR_W-1:2], 2'b00};
   assign dm_din        = merged;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

   // State register; reset forces IDLE and drops dm_we at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nxt;
   end

   // Next-state and state-decoded strobes.
   always_comb begin
      nxt           = state;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      dm_we         = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               unique case (1'b1)
                  !ok:
                     nxt = ST_ERR;
                  ok && !bus.req_we:
                     nxt = ST_LOAD;
                  ok && bus.req_we && bus.req_size == SZ_WORD:
                     nxt = ST_WRITE;
                  ok && bus.req_we && bus.req_size != SZ_WORD:
                     nxt = ST_READ;
               endcase
            end
         end
         ST_LOAD:  nxt = ST_RESP;
         ST_READ:  nxt = ST_WRITE;
         ST_WRITE: begin
            dm_we = 1'b1;
            nxt   = ST_RESP;
         end
         ST_ERR:   nxt = ST_RESP;
         ST_RESP: begin
            bus.rsp_valid = 1'b1;
            nxt           = ST_IDLE;
         end
         default:  nxt = ST_IDLE;
      endcase
   end

   // Request latch, RMW capture and response data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         sgn_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         merge_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            we_q    <= bus.req_we;
            sgn_q   <= bus.req_signed;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         case (state)
            ST_LOAD: begin
               rdata_q <= ext;
               err_q   <= 1'b0;
            end
            ST_READ:  merge_q <= dm_dout;
            ST_WRITE: begin
               rdata_q <= '0;
               err_q   <= 1'b0;
            end
            ST_ERR: begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   logic unused_we;
   assign unused_we = we_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a behavioural memory.
// Each task drives one scenario and checks inline.
module tb_dm_access_ctrl;
   import dm_acc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  dm_addr;
   logic [31:0] dm_din;
   logic [31:0] dm_dout;
   logic        dm_we;
   logic [31:0] mem [256];

   int vec = 0;
   int mis = 0;

   int          lat;
   int          wecnt;
   logic [31:0] r_data;
   logic        r_err;
   logic [31:0] w_din;
   logic [9:0]  w_addr;

   always #5 clk = ~clk;

   dm_access_ctrl_if #(.ADDR_W(10)) bus ();

   dm_access_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .dm_addr (dm_addr),
      .dm_din  (dm_din),
      .dm_we   (dm_we),
      .dm_dout (dm_dout)
   );

   assign dm_dout = mem[dm_addr[9:2]];

   always @(posedge clk)
      if (dm_we) mem[dm_addr[9:2]] <= dm_din;

   task automatic run_req(
      input logic        we,
      input logic [1:0]  sz,
      input logic        sg,
      input logic [9:0]  a,
      input logic [31:0] wd
   );
      @(negedge clk);
      vec++;
      if (bus.req_ready !== 1'b1) begin
         mis++;
         $display("FAIL ready_idle got %b want 1", bus.req_ready);
      end
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      @(posedge clk);
      lat    = 99;
      wecnt  = 0;
      r_data = 'x;
      r_err  = 1'bx;
      w_din  = 'x;
      w_addr = 'x;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) bus.req_valid = 1'b0;
         if (dm_we) begin
            wecnt++;
            w_din  = dm_din;
            w_addr = dm_addr;
         end
         if (bus.rsp_valid) begin
            lat    = i;
            r_data = bus.rsp_rdata;
            r_err  = bus.rsp_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      vec++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
          bus.rsp_err !== 1'b0 || dm_we !== 1'b0) begin
         mis++;
         $display("FAIL reset_ctl got rdy=%b v=%b e=%b we=%b want 1000",
                  bus.req_ready, bus.rsp_valid, bus.rsp_err, dm_we);
      end
      vec++;
      if (bus.rsp_rdata !== 32'h0 || dm_addr !== 10'h0 || dm_din !== 32'h0) begin
         mis++;
         $display("FAIL reset_data got rd=%h a=%h din=%h want 0",
                  bus.rsp_rdata, dm_addr, dm_din);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vec++;
      if (bus.req_ready !== 1'b1) begin
         mis++;
         $display("FAIL reset_release_ready got %b want 1", bus.req_ready);
      end
   endtask

   task automatic test_word();
      run_req(1'b1, SZ_WORD, 1'b0, 10'h010, 32'h11223344);
      vec++;
      if (lat !== 2 || wecnt !== 1 || r_err !== 1'b0) begin
         mis++;
         $display("FAIL sw_timing got lat=%0d we=%0d err=%b want 2 1 0",
                  lat, wecnt, r_err);
      end
      vec++;
      if (w_addr !== 10'h010 || w_din !== 32'h11223344) begin
         mis++;
         $display("FAIL sw_bus got a=%h din=%h want 010 11223344", w_addr, w_din);
      end
      vec++;
      if (mem[4] !== 32'h11223344) begin
         mis++;
         $display("FAIL sw_mem got %h want 11223344", mem[4]);
      end
      run_req(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0);
      vec++;
      if (lat !== 2 || wecnt !== 0 || r_err !== 1'b0 ||
          r_data !== 32'h11223344) begin
         mis++;
         $display("FAIL lw got lat=%0d we=%0d err=%b rd=%h want 2 0 0 11223344",
                  lat, wecnt, r_err, r_data);
      end
   endtask

   task automatic test_byte();
      run_req(1'b1, SZ_BYTE, 1'b0, 10'h013, 32'h000000AB);
      vec++;
      if (lat !== 3 || wecnt !== 1 || w_din !== 32'hAB223344) begin
         mis++;
         $display("FAIL sb got lat=%0d we=%0d din=%h want 3 1 ab223344",
                  lat, wecnt, w_din);
      end
      run_req(1'b0, SZ_BYTE, 1'b1, 10'h013, 32'h0);
      vec++;
      if (lat !== 2 || r_data !== 32'hFFFFFFAB || r_err !== 1'b0) begin
         mis++;
         $display("FAIL lb got lat=%0d rd=%h want 2 ffffffab", lat, r_data);
      end
      run_req(1'b0, SZ_BYTE, 1'b0, 10'h013, 32'h0);
      vec++;
      if (r_data !== 32'h000000AB) begin
         mis++;
         $display("FAIL lbu got %h want 000000ab", r_data);
      end
      run_req(1'b0, SZ_BYTE, 1'b1, 10'h011, 32'h0);
      vec++;
      if (r_data !== 32'h00000033) begin
         mis++;
         $display("FAIL lb_lane1 got %h want 00000033", r_data);
      end
   endtask

   task automatic test_half();
      run_req(1'b1, SZ_HALF, 1'b0, 10'h012, 32'h00008001);
      vec++;
      if (lat !== 3 || w_din !== 32'h80013344 || mem[4] !== 32'h80013344) begin
         mis++;
         $display("FAIL sh got lat=%0d din=%h mem=%h want 3 80013344",
                  lat, w_din, mem[4]);
      end
      run_req(1'b0, SZ_HALF, 1'b1, 10'h012, 32'h0);
      vec++;
      if (r_data !== 32'hFFFF8001) begin
         mis++;
         $display("FAIL lh got %h want ffff8001", r_data);
      end
      run_req(1'b0, SZ_HALF, 1'b0, 10'h012, 32'h0);
      vec++;
      if (r_data !== 32'h00008001) begin
         mis++;
         $display("FAIL lhu got %h want 00008001", r_data);
      end
      run_req(1'b0, SZ_HALF, 1'b1, 10'h010, 32'h0);
      vec++;
      if (r_data !== 32'h00003344) begin
         mis++;
         $display("FAIL lh_low got %h want 00003344", r_data);
      end
   endtask

   task automatic test_errors();
      logic       e_we [3];
      logic [1:0] e_sz [3];
      logic [9:0] e_a  [3];
      e_we = '{1'b0, 1'b1, 1'b1};
      e_sz = '{SZ_HALF, SZ_WORD, 2'b11};
      e_a  = '{10'h011, 10'h012, 10'h000};
      mem[0] = 32'h5A5A5A5A;
      for (int k = 0; k < 3; k++) begin
         run_req(e_we[k], e_sz[k], 1'b1, e_a[k], 32'hDEADBEEF);
         vec++;
         if (lat !== 2 || r_err !== 1'b1 || r_data !== 32'h0 || wecnt !== 0) begin
            mis++;
            $display("FAIL err%0d got lat=%0d err=%b rd=%h we=%0d want 2 1 0 0",
                     k, lat, r_err, r_data, wecnt);
         end
      end
      vec++;
      if (mem[4] !== 32'h80013344 || mem[0] !== 32'h5A5A5A5A) begin
         mis++;
         $display("FAIL err_mem got %h %h want 80013344 5a5a5a5a", mem[4], mem[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic rdy_exp [5];
      logic val_exp [5];
      rdy_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      val_exp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      mem[12] = 32'h01020304;
      mem[13] = 32'hA0B0C0D0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_size   = SZ_WORD;
      bus.req_signed = 1'b0;
      bus.req_addr   = 10'h030;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) bus.req_addr = 10'h034;
         vec++;
         if (bus.req_ready !== rdy_exp[i] || bus.rsp_valid !== val_exp[i]) begin
            mis++;
            $display("FAIL b2b_c%0d got rdy=%b v=%b want %b %b",
                     i + 1, bus.req_ready, bus.rsp_valid, rdy_exp[i], val_exp[i]);
         end
         if (i == 1) begin
            vec++;
            if (bus.rsp_rdata !== 32'h01020304) begin
               mis++;
               $display("FAIL b2b_rd1 got %h want 01020304", bus.rsp_rdata);
            end
         end
         if (i == 3) bus.req_valid = 1'b0;
         if (i == 4) begin
            vec++;
            if (bus.rsp_rdata !== 32'hA0B0C0D0) begin
               mis++;
               $display("FAIL b2b_rd2 got %h want a0b0c0d0", bus.rsp_rdata);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int wseen;
      wseen = 0;
      mem[8] = 32'hCAFEF00D;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_size   = SZ_BYTE;
      bus.req_signed = 1'b0;
      bus.req_addr   = 10'h020;
      bus.req_wdata  = 32'h00000055;
      @(negedge clk);
      bus.req_valid = 1'b0;
      vec++;
      if (bus.req_ready !== 1'b0 || dm_we !== 1'b0) begin
         mis++;
         $display("FAIL rmid_read got rdy=%b we=%b want 0 0", bus.req_ready, dm_we);
      end
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (dm_we) wseen++;
         @(negedge clk);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (dm_we) wseen++;
         vec++;
         if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            mis++;
            $display("FAIL rmid_idle got rdy=%b v=%b want 1 0",
                     bus.req_ready, bus.rsp_valid);
         end
      end
      vec++;
      if (wseen !== 0 || mem[8] !== 32'hCAFEF00D) begin
         mis++;
         $display("FAIL rmid_mem got we=%0d mem=%h want 0 cafef00d", wseen, mem[8]);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
